// File: rtl/fault_campaign_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fault_campaign_pkg
//  Purpose  : Shared types and constants for the stuck-at fault campaign
//             controller (state encoding, stuck-at constants, hang marker).
//  Revision : 1.0  initial release
// ============================================================================
package fault_campaign_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_G_ISSUE = 4'd1,
      ST_G_WAIT  = 4'd2,
      ST_CFG     = 4'd3,
      ST_SETTLE  = 4'd4,
      ST_R_ISSUE = 4'd5,
      ST_R_WAIT  = 4'd6,
      ST_REPORT  = 4'd7,
      ST_DONE    = 4'd8
   } state_t;

   localparam logic [31:0] SA0_CONST = 32'h0000_0000;
   localparam logic [31:0] SA1_CONST = 32'hFFFF_FFFF;
   // Prediction recorded in the golden store when the pipeline never answered
   localparam logic [31:0] HANG_PRED = 32'hFFFF_FFFF;

   // Constant driven onto the codeword line for a given stuck value
   function automatic logic [31:0] sa_const(input logic sa);
      return sa ? SA1_CONST : SA0_CONST;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fault_campaign_timer.sv
`default_nettype none
// ============================================================================
//  Module   : fault_campaign_timer
//  Purpose  : Loadable down-counter; expired is high whenever the count is 0.
//             Used both for the response timeout and the settle delay.
//  Revision : 1.0  initial release
// ============================================================================
module fault_campaign_timer #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] r_count;

   // Load has priority; otherwise count down and rest at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fault_campaign_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fault_campaign_ctrl
//  Purpose  : Runs a golden pass over N_IMG images, then reruns every image
//             for each (codeword bit, stuck value) fault point and reports
//             the number of predictions that differ from golden.
//  Revision : 1.0  initial release
// ============================================================================
module fault_campaign_ctrl
   import fault_campaign_pkg::*;
#(
   parameter int N_IMG   = 16,
   parameter int CW_BITS = 29,
   parameter int TIMEOUT = 256,
   parameter int SETTLE  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   output logic [$clog2(N_IMG)-1:0]     img_addr,
   output logic                         dut_valid,
   input  logic                         dut_ready,
   input  logic [31:0]                  dut_number,
   output logic                         fault_en,
   output logic [31:0]                  fault_const,
   output logic [4:0]                   fault_idx,
   output logic                         res_valid,
   output logic [4:0]                   res_idx,
   output logic                         res_sa,
   output logic [$clog2(N_IMG+1)-1:0]   res_miss,
   output logic                         busy,
   output logic                         done,
   output logic                         hang,
   output logic                         spurious
);

   localparam int ADDR_W  = $clog2(N_IMG);
   localparam int MISS_W  = $clog2(N_IMG + 1);
   localparam int PT_W    = $clog2(2 * CW_BITS);
   localparam int TMR_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [ADDR_W-1:0] c_last_img   = ADDR_W'(N_IMG - 1);
   localparam logic [PT_W-1:0]   c_last_pt    = PT_W'(2 * CW_BITS - 1);
   localparam logic [MISS_W-1:0] c_miss_max   = MISS_W'(N_IMG);
   // Timeout fires in the WAIT cycle that is TIMEOUT-1 cycles after dut_valid
   localparam logic [TMR_W-1:0]  c_tmo_load   = TMR_W'(TIMEOUT - 2);
   localparam logic [TMR_W-1:0]  c_settle_load = TMR_W'(SETTLE - 1);

   state_t              r_state;
   state_t              w_next;
   logic [PT_W-1:0]     r_point;
   logic [MISS_W-1:0]   r_miss;
   logic [31:0]         r_gold [N_IMG];

   logic                w_tmr_load;
   logic [TMR_W-1:0]    w_tmr_val;
   logic                w_tmr_exp;
   logic                w_in_wait;
   logic                w_resp;
   logic                w_tmo;
   logic                w_adv;
   logic                w_abort;
   logic                w_start_ok;
   logic                w_last_img;
   logic                w_last_pt;
   logic [31:0]         w_gold_rd;
   logic                w_mis;

   fault_campaign_timer #(
      .WIDTH    (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .expired  (w_tmr_exp)
   );

   assign w_in_wait  = (r_state == ST_G_WAIT) || (r_state == ST_R_WAIT);
   // A response arriving in the timeout cycle is taken as a normal response
   assign w_resp     = w_in_wait && dut_ready;
   assign w_tmo      = w_in_wait && w_tmr_exp && !dut_ready;
   assign w_adv      = w_resp || w_tmo;
   assign w_abort    = abort && (r_state != ST_IDLE);
   assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
   assign w_last_img = (img_addr == c_last_img);
   assign w_last_pt  = (r_point == c_last_pt);
   assign w_gold_rd  = r_gold[img_addr];
   assign w_mis      = w_tmo || (w_resp && (dut_number != w_gold_rd));

   assign res_idx    = fault_idx;
   assign res_sa     = fault_const[0];
   assign res_miss   = r_miss;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state, handshake strobes and timer control
   always_comb begin
      w_next     = r_state;
      dut_valid  = 1'b0;
      res_valid  = 1'b0;
      w_tmr_load = 1'b0;
      w_tmr_val  = c_tmo_load;
      case (r_state)
         ST_IDLE: begin
            if (start && !abort) w_next = ST_G_ISSUE;
         end
         ST_G_ISSUE: begin
            dut_valid  = 1'b1;
            w_tmr_load = 1'b1;
            w_next     = ST_G_WAIT;
         end
         ST_G_WAIT: begin
            if (w_adv) w_next = w_last_img ? ST_CFG : ST_G_ISSUE;
         end
         ST_CFG: begin
            w_tmr_load = 1'b1;
            w_tmr_val  = c_settle_load;
            w_next     = (SETTLE == 0) ? ST_R_ISSUE : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (w_tmr_exp) w_next = ST_R_ISSUE;
         end
         ST_R_ISSUE: begin
            dut_valid  = 1'b1;
            w_tmr_load = 1'b1;
            w_next     = ST_R_WAIT;
         end
         ST_R_WAIT: begin
            if (w_adv) w_next = w_last_img ? ST_REPORT : ST_R_ISSUE;
         end
         ST_REPORT: begin
            res_valid = 1'b1;
            w_next    = w_last_pt ? ST_DONE : ST_CFG;
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
      // Abort squashes any pulse of the current cycle and forces IDLE
      if (w_abort) begin
         w_next    = ST_IDLE;
         dut_valid = 1'b0;
         res_valid = 1'b0;
      end
   end

   // Campaign datapath: image pointer, fault point, miss count and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         img_addr    <= '0;
         fault_en    <= 1'b0;
         fault_const <= SA0_CONST;
         fault_idx   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hang        <= 1'b0;
         spurious    <= 1'b0;
         r_point     <= '0;
         r_miss      <= '0;
      end else if (w_start_ok) begin
         img_addr <= '0;
         fault_en <= 1'b0;
         busy     <= 1'b1;
         done     <= 1'b0;
         hang     <= 1'b0;
         spurious <= 1'b0;
         r_point  <= '0;
         r_miss   <= '0;
      end else begin
         if (dut_ready && !w_in_wait) spurious <= 1'b1;
         if (w_abort) begin
            fault_en <= 1'b0;
            busy     <= 1'b0;
         end else begin
            if (w_tmo) hang <= 1'b1;
            case (r_state)
               ST_G_WAIT: begin
                  if (w_adv && !w_last_img) img_addr <= img_addr + ADDR_W'(1);
               end
               ST_CFG: begin
                  fault_en    <= 1'b1;
                  fault_idx   <= 5'(r_point >> 1);
                  fault_const <= sa_const(r_point[0]);
                  img_addr    <= '0;
                  r_miss      <= '0;
               end
               ST_R_WAIT: begin
                  if (w_adv) begin
                     if (w_mis && (r_miss != c_miss_max)) r_miss <= r_miss + MISS_W'(1);
                     if (!w_last_img) img_addr <= img_addr + ADDR_W'(1);
                  end
               end
               ST_REPORT: begin
                  if (!w_last_pt) r_point <= r_point + PT_W'(1);
               end
               ST_DONE: begin
                  fault_en    <= 1'b0;
                  fault_const <= SA0_CONST;
                  fault_idx   <= '0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Golden prediction store; a hung image records the hang marker
   always_ff @(posedge clk) begin
      if ((r_state == ST_G_WAIT) && w_adv && !w_abort) begin
         r_gold[img_addr] <= w_resp ? dut_number : HANG_PRED;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fault_campaign_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fault_campaign_ctrl
//  Purpose  : Self-checking bench: pipeline model plus result scoreboard for
//             fault_campaign_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fault_campaign_ctrl;
   import fault_campaign_pkg::*;

   localparam int N_IMG   = 16;
   localparam int CW_BITS = 29;
   localparam int TIMEOUT = 256;
   localparam int SETTLE  = 2;
   localparam int LAT     = 5;
   localparam int NPT     = 2 * CW_BITS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  img_addr;
   logic        dut_valid;
   logic        dut_ready = 1'b0;
   logic [31:0] dut_number = '0;
   logic        fault_en;
   logic [31:0] fault_const;
   logic [4:0]  fault_idx;
   logic        res_valid;
   logic [4:0]  res_idx;
   logic        res_sa;
   logic [4:0]  res_miss;
   logic        busy, done, hang, spurious;

   typedef struct {
      logic [4:0] idx;
      logic       sa;
      logic [4:0] miss;
   } res_t;

   res_t        sb_q[$];
   int          n_total = 0;
   int          n_bad   = 0;
   int          n_res   = 0;
   int          cyc     = 0;

   // pipeline model knobs and state
   int          drop_img = -1;
   int          slow_img = -1;
   int          slow_lat = LAT;
   bit          inj_arm  = 1'b0;
   int          inj_cnt  = 0;
   int          pend     = 0;
   logic [31:0] pend_val = '0;
   int          t_drop   = -1;
   int          gap      = -1;

   fault_campaign_ctrl #(
      .N_IMG       (N_IMG),
      .CW_BITS     (CW_BITS),
      .TIMEOUT     (TIMEOUT),
      .SETTLE      (SETTLE)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .img_addr    (img_addr),
      .dut_valid   (dut_valid),
      .dut_ready   (dut_ready),
      .dut_number  (dut_number),
      .fault_en    (fault_en),
      .fault_const (fault_const),
      .fault_idx   (fault_idx),
      .res_valid   (res_valid),
      .res_idx     (res_idx),
      .res_sa      (res_sa),
      .res_miss    (res_miss),
      .busy        (busy),
      .done        (done),
      .hang        (hang),
      .spurious    (spurious)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // Pipeline model: answers each dut_valid after LAT cycles; bit 3 stuck-at-1 flips bit 0
   always @(negedge clk) begin
      int lat;
      dut_ready = 1'b0;
      if (!busy) begin
         pend = 0;
      end else if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            dut_ready  = 1'b1;
            dut_number = pend_val;
         end
      end
      if (dut_valid) begin
         lat = LAT;
         if (!fault_en && int'(img_addr) == slow_img) lat = slow_lat;
         if (!fault_en && t_drop >= 0 && int'(img_addr) == drop_img + 1) gap = cyc - t_drop;
         if (!fault_en && int'(img_addr) == drop_img) begin
            t_drop = cyc;
            pend   = 0;
         end else begin
            pend     = lat;
            pend_val = {28'd0, img_addr};
            if (fault_en && fault_idx == 5'd3 && fault_const == SA1_CONST) pend_val = pend_val ^ 32'd1;
         end
      end
      // stray response two cycles after a report lands in the settle window
      if (inj_arm && res_valid) begin
         inj_cnt = 2;
         inj_arm = 1'b0;
      end else if (inj_cnt > 0) begin
         inj_cnt--;
         if (inj_cnt == 0) begin
            dut_ready  = 1'b1;
            dut_number = 32'hDEAD_BEEF;
         end
      end
   end

   // Scoreboard consumer: every res_valid pops one expected result
   always @(negedge clk) begin
      res_t e;
      if (res_valid) begin
         n_res++;
         chk("res_expected", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("res_idx",  res_idx,  e.idx);
            chk("res_sa",   res_sa,   e.sa);
            chk("res_miss", res_miss, e.miss);
         end
      end
   end

   // Reference model of the campaign: golden pass then every fault point
   task automatic push_expect(input int drop);
      logic [31:0] g [N_IMG];
      logic [31:0] r;
      res_t        e;
      int          m;
      sb_q.delete();
      for (int i = 0; i < N_IMG; i++) g[i] = (i == drop) ? 32'hFFFF_FFFF : 32'(i);
      for (int p = 0; p < NPT; p++) begin
         m = 0;
         for (int i = 0; i < N_IMG; i++) begin
            r = 32'(i);
            if ((p / 2) == 3 && (p % 2) == 1) r = r ^ 32'd1;
            if (r != g[i]) m++;
         end
         if (m > N_IMG) m = N_IMG;
         e.idx  = 5'(p / 2);
         e.sa   = 1'(p % 2);
         e.miss = 5'(m);
         sb_q.push_back(e);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_res(input string tag, input int target, input int budget);
      int k = 0;
      while (n_res < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 64'(n_res >= target), 64'd1);
   endtask

   task automatic run_campaign(input string tag, input int drop, input bit exp_hang, input bit exp_spur);
      int k = 0;
      push_expect(drop);
      n_res = 0;
      pulse_start();
      chk({tag, "_busy"}, busy, 1'b1);
      while (done !== 1'b1 && k < 20000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_idle"}, {busy, fault_en, fault_const, fault_idx}, '0);
      chk({tag, "_hang"}, hang, exp_hang);
      chk({tag, "_spurious"}, spurious, exp_spur);
      chk({tag, "_nres"}, n_res, NPT);
      chk({tag, "_sb_empty"}, sb_q.size(), 0);
   endtask

   initial begin
      int k;
      // reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", {dut_valid, img_addr, fault_en, fault_const, fault_idx, res_valid,
                            res_idx, res_sa, res_miss, busy, done, hang, spurious}, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // start and abort together from IDLE: abort wins
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_abort_idle", {busy, dut_valid}, '0);

      // nominal campaign
      run_campaign("nominal", -1, 1'b0, 1'b0);

      // stray response during settle, then a clean rerun clears spurious
      inj_arm = 1'b1;
      run_campaign("spur", -1, 1'b0, 1'b1);
      run_campaign("rerun", -1, 1'b0, 1'b0);

      // golden image 7 never answered
      drop_img = 7;
      t_drop   = -1;
      gap      = -1;
      run_campaign("hang", 7, 1'b1, 1'b0);
      chk("hang_gap", gap, TIMEOUT);
      drop_img = -1;

      // response lands exactly in the timeout cycle
      slow_img = 5;
      slow_lat = TIMEOUT - 1;
      run_campaign("coincide", -1, 1'b0, 1'b0);
      slow_img = -1;

      // abort in R_WAIT of point (10,0)
      push_expect(-1);
      while (sb_q.size() > 20) void'(sb_q.pop_back());
      n_res = 0;
      pulse_start();
      wait_res("abort_reach", 20, 20000);
      k = 0;
      while (dut_valid !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("abort_issue_seen", dut_valid, 1'b1);
      @(negedge clk);
      chk("abort_point", {fault_en, fault_idx, fault_const}, {1'b1, 5'd10, SA0_CONST});
      abort = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_next", {busy, fault_en}, '0);
      @(negedge clk);
      abort = 1'b0;
      repeat (300) @(negedge clk);
      chk("abort_nres", n_res, 20);
      chk("abort_done", done, 1'b0);
      chk("abort_sb_empty", sb_q.size(), 0);

      // start while busy is ignored; async reset mid-campaign
      push_expect(-1);
      n_res = 0;
      pulse_start();
      wait_res("busy_reach5", 5, 20000);
      pulse_start();
      wait_res("busy_reach10", 10, 20000);
      chk("busy_after_start", busy, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset", {dut_valid, img_addr, fault_en, fault_const, fault_idx, res_valid,
                          res_idx, res_sa, res_miss, busy, done, hang, spurious}, '0);
      repeat (2) @(negedge clk);
      sb_q.delete();
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_reset_idle", {busy, dut_valid, res_valid}, '0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
